// File: rtl/cloud_proj_2d_if.sv
// Point stream between the pose transform and the correspondence search.
// Carries the incoming cloud sample with its intrinsics and the projected result.
//   i_valid, i_cloud_x/y/z, i_fx/i_fy, i_cx/i_cy : upstream sample (valid-only, no backpressure)
//   o_valid, o_u, o_v, o_depth, o_hit            : projected sample, registered
// master : producer/consumer side (drives inputs, reads results)
// slave  : projection block
interface cloud_proj_2d_if #(
    parameter int unsigned CLOUD_BW = 42,
    parameter int unsigned INTR_BW  = 32,
    parameter int unsigned COORD_BW = 11
);
    logic                i_valid;
    logic [CLOUD_BW-1:0] i_cloud_x;
    logic [CLOUD_BW-1:0] i_cloud_y;
    logic [CLOUD_BW-1:0] i_cloud_z;
    logic [INTR_BW-1:0]  i_fx;
    logic [INTR_BW-1:0]  i_fy;
    logic [COORD_BW-1:0] i_cx;
    logic [COORD_BW-1:0] i_cy;

    logic                o_valid;
    logic [COORD_BW-1:0] o_u;
    logic [COORD_BW-1:0] o_v;
    logic [CLOUD_BW-1:0] o_depth;
    logic                o_hit;

    modport master (
        output i_valid, i_cloud_x, i_cloud_y, i_cloud_z, i_fx, i_fy, i_cx, i_cy,
        input  o_valid, o_u, o_v, o_depth, o_hit
    );

    modport slave (
        input  i_valid, i_cloud_x, i_cloud_y, i_cloud_z, i_fx, i_fy, i_cx, i_cy,
        output o_valid, o_u, o_v, o_depth, o_hit
    );
endinterface

// File: rtl/cloud_proj_2d.sv
// Pinhole projection of pose-transformed cloud points to pixel coordinates:
//   u = trunc(fx*x/z) + cx, v = trunc(fy*y/z) + cy
// Fully pipelined, one point per cycle, latency QUO_BW+3, order preserved.
// Ports:
//   i_clk : clock
//   i_rst : asynchronous reset, active-high; drops every in-flight sample
//   bus   : cloud_proj_2d_if.slave (input sample + intrinsics, projected output)
module cloud_proj_2d #(
    parameter int unsigned CLOUD_BW = 42,
    parameter int unsigned FRAC     = 16,
    parameter int unsigned INTR_BW  = 32,
    parameter int unsigned QUO_BW   = 12,
    parameter int unsigned COORD_BW = 11,
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480
) (
    input  logic             i_clk,
    input  logic             i_rst,
    cloud_proj_2d_if.slave   bus
);

    localparam int unsigned P_W  = CLOUD_BW + INTR_BW;              // product width
    localparam int unsigned D_W  = P_W - FRAC;                      // dividend magnitude width
    localparam int unsigned ZS_W = CLOUD_BW + QUO_BW;               // z << QUO_BW width
    localparam int unsigned C_W  = ((D_W > ZS_W) ? D_W : ZS_W) + 1; // divider compare width
    localparam int unsigned S_W  = QUO_BW + 2;                      // signed pixel sum width

    // Per-stage divider payload; x and y share the divisor.
    typedef struct packed {
        logic [D_W-1:0]      rem_x;
        logic [D_W-1:0]      rem_y;
        logic [QUO_BW-1:0]   quo_x;
        logic [QUO_BW-1:0]   quo_y;
        logic                sgn_x;
        logic                sgn_y;
        logic                miss;
        logic [CLOUD_BW-1:0] dvs;
        logic [CLOUD_BW-1:0] z;
        logic [COORD_BW-1:0] cx;
        logic [COORD_BW-1:0] cy;
    } div_t;

    // One restoring step producing quotient bit b for both axes.
    function automatic div_t div_step(input div_t s, input int unsigned b);
        div_t           r;
        logic [C_W-1:0] sub;
        r   = s;
        sub = C_W'(s.dvs) << b;
        if (C_W'(s.rem_x) >= sub) begin
            r.rem_x = D_W'(C_W'(s.rem_x) - sub);
            r.quo_x = s.quo_x | (QUO_BW'(1) << b);
        end
        if (C_W'(s.rem_y) >= sub) begin
            r.rem_y = D_W'(C_W'(s.rem_y) - sub);
            r.quo_y = s.quo_y | (QUO_BW'(1) << b);
        end
        return r;
    endfunction

    // ---------------- Stage 1: focal multiply ----------------
    logic [P_W-1:0] px_c, py_c;
    assign px_c = $signed({{INTR_BW{bus.i_cloud_x[CLOUD_BW-1]}}, bus.i_cloud_x})
                * $signed({{CLOUD_BW{1'b0}}, bus.i_fx});
    assign py_c = $signed({{INTR_BW{bus.i_cloud_y[CLOUD_BW-1]}}, bus.i_cloud_y})
                * $signed({{CLOUD_BW{1'b0}}, bus.i_fy});

    logic                s1_vld;
    logic [P_W-1:0]      s1_px, s1_py;
    logic [CLOUD_BW-1:0] s1_z;
    logic [COORD_BW-1:0] s1_cx, s1_cy;

    always_ff @(posedge i_clk) begin
        s1_px <= px_c;
        s1_py <= py_c;
        s1_z  <= bus.i_cloud_z;
        s1_cx <= bus.i_cx;
        s1_cy <= bus.i_cy;
    end

    // ---------------- Stage 2: rescale, sign/magnitude split, range flags ----------------
    logic [P_W-1:0]  nx_c, ny_c;
    logic [D_W-1:0]  mag_x_c, mag_y_c;
    logic [C_W-1:0]  zsh_c;
    logic            zbad_c, ovf_x_c, ovf_y_c;
    div_t            s2_c;

    assign nx_c    = $unsigned($signed(s1_px) >>> FRAC);
    assign ny_c    = $unsigned($signed(s1_py) >>> FRAC);
    assign mag_x_c = D_W'(nx_c[P_W-1] ? (P_W'(0) - nx_c) : nx_c);
    assign mag_y_c = D_W'(ny_c[P_W-1] ? (P_W'(0) - ny_c) : ny_c);
    assign zbad_c  = s1_z[CLOUD_BW-1] | (s1_z == '0);
    assign zsh_c   = C_W'(s1_z) << QUO_BW;
    assign ovf_x_c = C_W'(mag_x_c) >= zsh_c;
    assign ovf_y_c = C_W'(mag_y_c) >= zsh_c;

    always_comb begin
        s2_c       = '0;
        s2_c.rem_x = mag_x_c;
        s2_c.rem_y = mag_y_c;
        s2_c.sgn_x = nx_c[P_W-1];
        s2_c.sgn_y = ny_c[P_W-1];
        s2_c.miss  = zbad_c | ovf_x_c | ovf_y_c;
        // Non-positive depth divides by 1 so the pipe never sees an undefined divisor.
        s2_c.dvs   = zbad_c ? CLOUD_BW'(1) : s1_z;
        s2_c.z     = s1_z;
        s2_c.cx    = s1_cx;
        s2_c.cy    = s1_cy;
    end

    logic s2_vld;
    div_t s2;

    always_ff @(posedge i_clk) begin
        s2 <= s2_c;
    end

    // ---------------- Divider: one quotient bit per stage, MSB first ----------------
    div_t              dq [QUO_BW];
    logic [QUO_BW-1:0] dq_vld;

    always_ff @(posedge i_clk) begin
        dq[0] <= div_step(s2, QUO_BW - 1);
        for (int unsigned k = 1; k < QUO_BW; k++) begin
            dq[k] <= div_step(dq[k-1], QUO_BW - 1 - k);
        end
    end

    // ---------------- Final: signed quotient, principal point, image bounds ----------------
    div_t           fin;
    logic [S_W-1:0] qx_c, qy_c, su_c, sv_c;
    logic           hit_c;

    assign fin   = dq[QUO_BW-1];
    assign qx_c  = fin.sgn_x ? (S_W'(0) - S_W'(fin.quo_x)) : S_W'(fin.quo_x);
    assign qy_c  = fin.sgn_y ? (S_W'(0) - S_W'(fin.quo_y)) : S_W'(fin.quo_y);
    assign su_c  = qx_c + S_W'(fin.cx);
    assign sv_c  = qy_c + S_W'(fin.cy);
    assign hit_c = !fin.miss
                 && !su_c[S_W-1] && (su_c < S_W'(IMG_W))
                 && !sv_c[S_W-1] && (sv_c < S_W'(IMG_H));

    // Valid chain and outputs; reset discards every sample in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld      <= 1'b0;
            s2_vld      <= 1'b0;
            dq_vld      <= '0;
            bus.o_valid <= 1'b0;
            bus.o_u     <= '0;
            bus.o_v     <= '0;
            bus.o_depth <= '0;
            bus.o_hit   <= 1'b0;
        end else begin
            s1_vld      <= bus.i_valid;
            s2_vld      <= s1_vld;
            dq_vld      <= {dq_vld[QUO_BW-2:0], s2_vld};
            bus.o_valid <= dq_vld[QUO_BW-1];
            // Output data holds between valid samples.
            if (dq_vld[QUO_BW-1]) begin
                bus.o_u     <= hit_c ? su_c[COORD_BW-1:0] : '0;
                bus.o_v     <= hit_c ? sv_c[COORD_BW-1:0] : '0;
                bus.o_depth <= fin.z;
                bus.o_hit   <= hit_c;
            end
        end
    end

endmodule
